// File: rtl/imem_responder_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
//   Shared definitions for the instruction-memory responder.
//   - state_t         : responder phase (LOAD -> TERM -> RUN)
//   - TERM_OP_DEFAULT : default halt opcode written after the last program byte
//   - depth_of()      : RAM depth for a given address width
// -----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        LOAD,
        TERM,
        RUN
    } state_t;

    localparam int unsigned TERM_OP_DEFAULT = 0;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/imem_responder_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
//   Single-port synchronous RAM holding the program image.
//   Ports:
//     clk      in   clock
//     reset_n  in   async active-low reset (read register only, not the array)
//     we       in   write enable
//     addr     in   [A_WIDTH]  shared read/write address
//     wdata    in   [D_WIDTH]  write data
//     re       in   read enable; rdata updates from mem[addr] when set
//     rclr     in   synchronous clear of the read register (wins over re)
//     rdata    out  [D_WIDTH]  registered read data
// -----------------------------------------------------------------------------
module imem_ram
    import imem_pkg::*;
#(
    parameter int unsigned A_WIDTH = 12,
    parameter int unsigned D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we,
    input  logic [A_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               re,
    input  logic               rclr,
    output logic [D_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = depth_of(A_WIDTH);

    logic [D_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder for the fetch stage. A host first streams the
//   program into RAM over a valid/ready byte interface; a terminator opcode is
//   then appended and core_run is raised. In RUN, fetches (ice/ia) return the
//   opcode on id one cycle later.
//   Optional feature: define IMEM_CHECKSUM_EN to add a checksum output (sum
//   modulo 2**D_WIDTH of accepted host bytes).
//   Ports:
//     clk       in   clock
//     reset_n   in   async active-low reset
//     ice       in   fetch enable
//     ia        in   [A_WIDTH] fetch address
//     id        out  [D_WIDTH] fetched opcode (registered)
//     ld_valid  in   host byte valid
//     ld_data   in   [D_WIDTH] host program byte
//     ld_last   in   final program byte marker
//     ld_ready  out  byte accepted this cycle when ld_valid is high
//     reload    in   in RUN: restart loading from address 0
//     core_run  out  program loaded, fetch side may run
//     overflow  out  sticky: program truncated at DEPTH-1
//     checksum  out  [D_WIDTH] (IMEM_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned         A_WIDTH = 12,
    parameter int unsigned         D_WIDTH = 8,
    parameter logic [D_WIDTH-1:0]  TERM_OP = D_WIDTH'(TERM_OP_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ice,
    input  logic [A_WIDTH-1:0] ia,
    output logic [D_WIDTH-1:0] id,
    input  logic               ld_valid,
    input  logic [D_WIDTH-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    input  logic               reload,
    output logic               core_run,
    output logic               overflow
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [D_WIDTH-1:0] checksum
`endif
);

    localparam int unsigned        DEPTH     = depth_of(A_WIDTH);
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

    state_t             state_q;
    logic [A_WIDTH-1:0] wr_addr_q;
    logic [A_WIDTH-1:0] wr_addr_inc;
    logic               ld_ready_q;
    logic               core_run_q;
    logic               overflow_q;
    logic               xfer;

    logic               ram_we;
    logic [A_WIDTH-1:0] ram_addr;
    logic [D_WIDTH-1:0] ram_wdata;
    logic               ram_re;
    logic               ram_rclr;

    assign xfer        = (state_q == LOAD) && ld_valid && ld_ready_q;
    assign wr_addr_inc = wr_addr_q + A_WIDTH'(1);

    // ld_ready is registered from the post-edge state/address, so it is 0 in
    // the first cycle after reset and drops the same edge that ends loading.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LOAD;
            wr_addr_q  <= '0;
            ld_ready_q <= 1'b0;
            core_run_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (xfer) begin
                        wr_addr_q <= wr_addr_inc;
                        if (ld_last) begin
                            state_q    <= TERM;
                            ld_ready_q <= 1'b0;
                        end else if (wr_addr_inc == LAST_ADDR) begin
                            // Last slot is reserved for the terminator.
                            state_q    <= TERM;
                            overflow_q <= 1'b1;
                            ld_ready_q <= 1'b0;
                        end else begin
                            ld_ready_q <= 1'b1;
                        end
                    end else begin
                        ld_ready_q <= (wr_addr_q != LAST_ADDR);
                    end
                end
                TERM: begin
                    state_q    <= RUN;
                    ld_ready_q <= 1'b0;
                    core_run_q <= 1'b1;
                end
                RUN: begin
                    ld_ready_q <= 1'b0;
                    if (reload) begin
                        state_q    <= LOAD;
                        wr_addr_q  <= '0;
                        core_run_q <= 1'b0;
                        overflow_q <= 1'b0;
                        ld_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= LOAD;
                    ld_ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [D_WIDTH-1:0] checksum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else if (xfer) begin
            checksum_q <= checksum_q + ld_data;
        end else if ((state_q == RUN) && reload) begin
            checksum_q <= '0;
        end
    end

    assign checksum = checksum_q;
`endif

    // RAM port sharing: loader owns the address in LOAD/TERM, fetch in RUN.
    // reload clears the read register so id returns to 0 with LOAD.
    always_comb begin
        ram_we    = xfer || (state_q == TERM);
        ram_wdata = (state_q == TERM) ? TERM_OP : ld_data;
        ram_addr  = (state_q == RUN) ? ia : wr_addr_q;
        ram_re    = (state_q == RUN) && ice && !reload;
        ram_rclr  = (state_q == RUN) && reload;
    end

    imem_ram #(
        .A_WIDTH (A_WIDTH),
        .D_WIDTH (D_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (ram_wdata),
        .re      (ram_re),
        .rclr    (ram_rclr),
        .rdata   (id)
    );

    assign ld_ready = ld_ready_q;
    assign core_run = core_run_q;
    assign overflow = overflow_q;

endmodule
